// File: rtl/umi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : umi_rr_arbiter
// Description : N-to-1 round-robin UMI arbiter with a one-slot registered
//               output stage. Optional starvation protection: UMI_ARB_STARVE_EN
// Revision    : 1.0 - initial release
// ============================================================================
module umi_rr_arbiter #(
    parameter int N       = 4,
    parameter int UW      = 256,
    parameter int MAXWAIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*UW-1:0] umi_in_packet,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [UW-1:0]   umi_out_packet,
    input  logic            umi_out_ready,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    starve
);

    localparam int         c_pw      = $clog2(N);
    localparam logic [7:0] c_maxwait = 8'(MAXWAIT);

    logic [c_pw-1:0] r_ptr;
    logic            r_out_valid;
    logic [UW-1:0]   r_out_packet;

    logic            w_load_en;
    logic            w_found;
    logic            w_accept;
    logic [c_pw-1:0] w_win;
    logic [c_pw-1:0] w_ptr_nxt;
    logic [c_pw:0]   w_scan;
    logic [UW-1:0]   w_win_packet;
    logic [N-1:0]    w_ready;
    logic [N-1:0]    w_starve_req;

`ifdef UMI_ARB_STARVE_EN
    logic [7:0]      r_wait [N];
    logic [7:0]      w_wait_nxt [N];
    logic [N-1:0]    r_starve;

    assign w_starve_req = r_starve & umi_in_valid;
    assign starve       = r_starve;
`else
    logic [7:0]      w_unused_maxwait;

    assign w_unused_maxwait = c_maxwait;
    assign w_starve_req     = '0;
    assign starve           = '0;
`endif

    // Slot can take a new packet when empty or draining this cycle
    assign w_load_en = ~r_out_valid | umi_out_ready;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_ptr} + (c_pw+1)'(k);
            if (w_scan >= (c_pw+1)'(N))
                w_scan = w_scan - (c_pw+1)'(N);
            if (!w_found && umi_in_valid[w_scan[c_pw-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[c_pw-1:0];
            end
        end
`ifdef UMI_ARB_STARVE_EN
        // Descending scan so the lowest-index starving requester wins last
        for (int i = N-1; i >= 0; i--) begin
            if (w_starve_req[i]) begin
                w_found = 1'b1;
                w_win   = c_pw'(i);
            end
        end
`endif
    end

    always_comb begin
        w_win_packet = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == c_pw'(i))
                w_win_packet = umi_in_packet[i*UW +: UW];
        end
    end

    assign w_accept  = w_found & w_load_en & ~reset;
    assign w_ready   = w_accept ? (N'(1) << w_win) : '0;
    assign w_ptr_nxt = (w_win == c_pw'(N-1)) ? '0 : w_win + 1'b1;

    assign umi_in_ready   = w_ready;
    assign grant          = w_ready & umi_in_valid;
    assign umi_out_valid  = r_out_valid;
    assign umi_out_packet = r_out_packet;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
            r_ptr        <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_packet <= w_win_packet;
                r_ptr        <= w_ptr_nxt;
            end
        end
    end

`ifdef UMI_ARB_STARVE_EN
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_wait_nxt[i] = r_wait[i];
            if (!umi_in_valid[i] || w_ready[i])
                w_wait_nxt[i] = '0;
            else if (r_wait[i] != 8'hFF)
                w_wait_nxt[i] = r_wait[i] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                r_wait[i] <= '0;
            r_starve <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_wait[i]   <= w_wait_nxt[i];
                r_starve[i] <= (w_wait_nxt[i] >= c_maxwait);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_umi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_umi_rr_arbiter
// Description : Self-checking bench for umi_rr_arbiter (N=4, UW=16, MAXWAIT=4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umi_rr_arbiter;

    localparam int N       = 4;
    localparam int UW      = 16;
    localparam int MAXWAIT = 4;
    localparam int PW      = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    umi_in_valid;
    logic [N*UW-1:0] umi_in_packet;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [UW-1:0]   umi_out_packet;
    logic            umi_out_ready;
    logic [N-1:0]    grant;
    logic [N-1:0]    starve;
    logic [UW-1:0]   pkts [N];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        umi_in_packet = '0;
        for (int i = 0; i < N; i++)
            umi_in_packet[i*UW +: UW] = pkts[i];
    end

    umi_rr_arbiter #(.N(N), .UW(UW), .MAXWAIT(MAXWAIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .umi_in_valid   (umi_in_valid),
        .umi_in_packet  (umi_in_packet),
        .umi_in_ready   (umi_in_ready),
        .umi_out_valid  (umi_out_valid),
        .umi_out_packet (umi_out_packet),
        .umi_out_ready  (umi_out_ready),
        .grant          (grant),
        .starve         (starve)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Reference model: slot contents, pointer and wait counts as plain integers
    bit            started = 1'b0;
    int            m_ptr = 0, n_ptr = 0;
    bit            m_valid = 1'b0, n_valid = 1'b0;
    logic [UW-1:0] m_pkt = '0, n_pkt = '0;
    int            m_wait [N];
    int            n_wait [N];
    bit [N-1:0]    m_starve = '0, n_starve = '0;
    bit            e_load, e_found;
    logic [PW-1:0] e_win, e_ix;
    logic [N-1:0]  e_ready, e_starve;

    always @(negedge clk) begin
        if (started) begin
            e_load  = !m_valid || (umi_out_ready === 1'b1);
            e_found = 1'b0;
            e_win   = '0;
            for (int k = 0; k < N; k++) begin
                e_ix = PW'((m_ptr + k) % N);
                if (!e_found && umi_in_valid[e_ix]) begin
                    e_found = 1'b1;
                    e_win   = e_ix;
                end
            end
`ifdef UMI_ARB_STARVE_EN
            e_starve = m_starve;
            for (int i = 0; i < N; i++) begin
                if (m_starve[i] && umi_in_valid[i] && !(e_found && e_win < PW'(i) && m_starve[e_win])) begin
                    e_found = 1'b1;
                    e_win   = PW'(i);
                    break;
                end
            end
`else
            e_starve = '0;
`endif
            e_ready = (!reset && e_load && e_found) ? (N'(1) << e_win) : '0;
            chk("in_ready", umi_in_ready, e_ready);
            chk("grant", grant, e_ready);
            chk("out_valid", umi_out_valid, m_valid);
            chk("out_packet", umi_out_packet, m_pkt);
            chk("starve", starve, e_starve);

            n_ptr = m_ptr; n_valid = m_valid; n_pkt = m_pkt; n_starve = m_starve;
            for (int i = 0; i < N; i++) n_wait[i] = m_wait[i];
            if (reset) begin
                n_ptr = 0; n_valid = 1'b0; n_pkt = '0; n_starve = '0;
                for (int i = 0; i < N; i++) n_wait[i] = 0;
            end else begin
                if (e_load) begin
                    n_valid = (e_ready != '0);
                    if (e_ready != '0) begin
                        n_pkt = pkts[e_win];
                        n_ptr = (int'(e_win) + 1) % N;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (!umi_in_valid[i] || e_ready[i]) n_wait[i] = 0;
                    else if (m_wait[i] < 255) n_wait[i] = m_wait[i] + 1;
                    n_starve[i] = (n_wait[i] >= MAXWAIT);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset && !started) begin
            started  <= 1'b1;
            m_ptr    <= 0;
            m_valid  <= 1'b0;
            m_pkt    <= '0;
            m_starve <= '0;
            for (int i = 0; i < N; i++) m_wait[i] <= 0;
        end else if (started) begin
            m_ptr    <= n_ptr;
            m_valid  <= n_valid;
            m_pkt    <= n_pkt;
            m_starve <= n_starve;
            for (int i = 0; i < N; i++) m_wait[i] <= n_wait[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        umi_in_valid  = 4'b1111;
        umi_out_ready = 1'b1;
        for (int i = 0; i < N; i++) pkts[i] = 16'hA0 + 16'(i);

        // Reset held two cycles with every requester valid
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", umi_in_ready, 4'b0000);
            chk("rst_out_valid", umi_out_valid, 1'b0);
            chk("rst_starve", starve, 4'b0000);
            tick();
        end
        reset = 1'b0;

        // Fairness: grants rotate 0..3, outputs A0..A3 one per cycle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fair_grant", grant, 4'b0001 << (k % 4));
            if (k > 0) chk("fair_packet", umi_out_packet, 16'hA0 + 16'((k - 1) % 4));
            tick();
        end

        // Backpressure: load A1, stall five cycles, resume
        umi_in_valid = 4'b0010;
        @(negedge clk);
        chk("bp_load_grant", grant, 4'b0010);
        tick();
        umi_in_valid  = 4'b0100;
        umi_out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_packet", umi_out_packet, 16'hA1);
            chk("bp_hold_ready", umi_in_ready, 4'b0000);
            tick();
        end
        umi_in_valid  = 4'b1111;
        umi_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_grant", grant, 4'b0100);
        tick();

        // Drain with nobody requesting
        umi_in_valid = 4'b0000;
        @(negedge clk);
        chk("drain_packet", umi_out_packet, 16'hA2);
        tick();
        @(negedge clk);
        chk("drain_valid", umi_out_valid, 1'b0);
        chk("drain_hold_packet", umi_out_packet, 16'hA2);
        tick();

        // Wrap: pointer at 3, only requesters 3 and 0
        umi_in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wrap_grant", grant, (k % 2 == 0) ? 4'b1000 : 4'b0001);
            tick();
        end

        // Requester 2 waits four stalled cycles, then competes with 0 and 1
        umi_in_valid  = 4'b0100;
        umi_out_ready = 1'b0;
        repeat (4) tick();
        umi_in_valid  = 4'b0111;
        umi_out_ready = 1'b1;
        @(negedge clk);
`ifdef UMI_ARB_STARVE_EN
        chk("starve_set", starve, 4'b0100);
        chk("starve_grant", grant, 4'b0100);
`else
        chk("starve_set", starve, 4'b0000);
        chk("starve_grant", grant, 4'b0010);
`endif
        tick();
        umi_in_valid  = 4'b0000;
        umi_out_ready = 1'b0;
        @(negedge clk);
        chk("starve_clear", starve, 4'b0000);
        tick();

        // Mid-operation reset with the slot full and stalled
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_full", umi_out_valid, 1'b1);
        tick();
        reset         = 1'b0;
        umi_out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", umi_out_valid, 1'b0);
        chk("mid_rst_packet", umi_out_packet, 16'h0000);
        tick();
        umi_in_valid = 4'b0001;
        @(negedge clk);
        chk("post_rst_grant", grant, 4'b0001);
        tick();
        umi_in_valid = 4'b0000;
        @(negedge clk);
        chk("post_rst_packet", umi_out_packet, 16'hA0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
